wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 39 +++
 rtl/wb_arbiter.sv | 74 +++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/LSU writeback requests, load-issue/hazard queries
// and the register-file write port.
interface wb_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int REGID_W = 5
);
  logic               alu_valid;
  logic [REGID_W-1:0] alu_rd;
  logic [XLEN-1:0]    alu_data;
  logic               alu_ready;
  logic               lsu_valid;
  logic [REGID_W-1:0] lsu_rd;
  logic [XLEN-1:0]    lsu_data;
  logic               lsu_ready;
  logic               ld_issue;
  logic [REGID_W-1:0] ld_issue_rd;
  logic [REGID_W-1:0] rs1_addr;
  logic [REGID_W-1:0] rs2_addr;
  logic               rs1_busy;
  logic               rs2_busy;
  logic [REGID_W-1:0] rd_addr;
  logic [XLEN-1:0]    rd_wdata;
  logic               rd_write;
  logic               ld_pending;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           ld_issue, ld_issue_rd, rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, rs1_busy, rs2_busy,
           rd_addr, rd_wdata, rd_write, ld_pending
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           ld_issue, ld_issue_rd, rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
           rd_addr, rd_wdata, rd_write, ld_pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin ALU/LSU writeback arbiter with a one-cycle registered write port
// and a per-register pending-load scoreboard for hazard queries.
module wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int REGID_W = 5,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_b,
  wb_arbiter_if.slave   bus
);
  localparam int NREG = 1 << REGID_W;

  typedef enum logic {WIN_ALU, WIN_LSU} winner_e;

  winner_e            last_winner, last_winner_next;
  logic               grant_alu, grant_lsu, conflict;
  logic [NREG-1:0]    sb, sb_next;
  logic               rd_write_q;
  logic [REGID_W-1:0] rd_addr_q;
  logic [XLEN-1:0]    rd_wdata_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    conflict         = bus.alu_valid && bus.lsu_valid;
    grant_alu        = bus.alu_valid && (!bus.lsu_valid || last_winner == WIN_LSU);
    grant_lsu        = bus.lsu_valid && !grant_alu;
    last_winner_next = last_winner;
    if (conflict)
      last_winner_next = grant_alu ? WIN_ALU : WIN_LSU;

    // Clear before set: a new load to the same register stays pending.
    sb_next = sb;
    if (grant_lsu)
      sb_next[bus.lsu_rd] = 1'b0;
    if (bus.ld_issue && !(R0_ZERO && bus.ld_issue_rd == '0))
      sb_next[bus.ld_issue_rd] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the scoreboard array is reset explicitly; stale pending bits would stall issue.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_winner <= WIN_LSU;
      sb          <= '0;
      rd_write_q  <= 1'b0;
      rd_addr_q   <= '0;
      rd_wdata_q  <= '0;
    end else begin
      last_winner <= last_winner_next;
      sb          <= sb_next;
      if (grant_alu) begin
        rd_addr_q  <= bus.alu_rd;
        rd_wdata_q <= bus.alu_data;
        rd_write_q <= !(R0_ZERO && bus.alu_rd == '0);
      end else if (grant_lsu) begin
        rd_addr_q  <= bus.lsu_rd;
        rd_wdata_q <= bus.lsu_data;
        rd_write_q <= !(R0_ZERO && bus.lsu_rd == '0);
      end else begin
        rd_write_q <= 1'b0;
      end
    end
  end

  assign bus.alu_ready  = grant_alu;
  assign bus.lsu_ready  = grant_lsu;
  assign bus.rd_write   = rd_write_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_wdata   = rd_wdata_q;
  assign bus.ld_pending = |sb;
  assign bus.rs1_busy   = sb[bus.rs1_addr] && !(R0_ZERO && bus.rs1_addr == '0);
  assign bus.rs2_busy   = sb[bus.rs2_addr] && !(R0_ZERO && bus.rs2_addr == '0);
endmodule
